// File: rtl/conv1_pkg.sv
// conv1 window feeder shared types and constants.
// Kernel geometry, slot cadence and the output FSM state.
package conv1_pkg;

  localparam int KSIZE  = 3;
  localparam int NTAPS  = 9;
  localparam int NSLOTS = 10;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  function automatic logic [1:0] inc3(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic logic [1:0] dec3(input logic [1:0] s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

endpackage

// File: rtl/conv1_window_feeder_if.sv
// Pixel stream in, tap stream out for the conv1 window feeder.
// slave = feeder side, master = source/datapath side.
interface conv1_window_feeder_if #(
  parameter int pDATA_WIDTH = 8,
  parameter int pIN_CHANNEL = 3,
  parameter int pKERNEL_NUM = 9
);
  localparam int PW  = pDATA_WIDTH * pIN_CHANNEL;
  localparam int KAW = $clog2(pKERNEL_NUM);

  logic           s_valid;
  logic           s_ready;
  logic [PW-1:0]  s_data;
  logic           win_ready;
  logic           en;
  logic [KAW-1:0] kernel_addr;
  logic [PW-1:0]  data_out;
  logic           tap_first;
  logic           tap_last;
  logic           frame_done;

  modport master (
    output s_valid, s_data, win_ready,
    input  s_ready, en, kernel_addr, data_out,
    input  tap_first, tap_last, frame_done
  );

  modport slave (
    input  s_valid, s_data, win_ready,
    output s_ready, en, kernel_addr, data_out,
    output tap_first, tap_last, frame_done
  );
endinterface

// File: rtl/conv1_line_ram.sv
// Simple dual-port synchronous RAM, one write and one read port.
// Read data is registered (1-cycle latency); maps onto block RAM.
module conv1_line_ram #(
  parameter int DEPTH = 96,
  parameter int WIDTH = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data_q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

endmodule

// File: rtl/conv1_window_feeder.sv
// conv1 window feeder: 3x3, stride 1, pad 1 over a 3-row line ring.
// Emits 9 taps plus a zero slot per window, 10 cycles each.
module conv1_window_feeder
  import conv1_pkg::*;
#(
  parameter int pDATA_WIDTH = 8,
  parameter int pIN_CHANNEL = 3,
  parameter int pIMG_W      = 32,
  parameter int pIMG_H      = 32,
  parameter int pKERNEL_NUM = 9
) (
  input  logic clk,
  input  logic rst_n,
  conv1_window_feeder_if.slave bus
);

  localparam int PW    = pDATA_WIDTH * pIN_CHANNEL;
  localparam int KAW   = $clog2(pKERNEL_NUM);
  localparam int CW    = $clog2(pIMG_W);
  localparam int RW    = $clog2(pIMG_H + 1);
  localparam int SW    = $clog2(NSLOTS);
  localparam int DEPTH = KSIZE * pIMG_W;
  localparam int AW    = $clog2(DEPTH);

  state_e         state_q, state_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic [CW-1:0]  out_col_q, out_col_d;
  logic [RW-1:0]  out_row_q, out_row_d;
  logic [1:0]     out_slot_q, out_slot_d;
  logic [CW-1:0]  in_col_q, in_col_d;
  logic [RW-1:0]  in_row_q, in_row_d;
  logic [1:0]     in_slot_q, in_slot_d;
  logic           en_q, en_d;
  logic [KAW-1:0] kaddr_q, kaddr_d;
  logic           pad_q, pad_d;
  logic           first_q, first_d;
  logic           last_q, last_d;
  logic           done_q, done_d;

  logic           ready_c, wr_en, rd_en, issue, pad_c;
  logic [RW:0]    orow1;
  logic [AW-1:0]  wr_addr, rd_addr;
  logic [PW-1:0]  rd_data;
  logic [1:0]     ky, kx, rd_slot;
  logic [SW-1:0]  base;
  logic [CW-1:0]  rd_col, nxt_col;
  logic [RW-1:0]  nxt_row;
  logic [1:0]     nxt_oslot;
  logic           last_col, last_row;

  function automatic logic rows_ok(
    input logic [RW-1:0] row,
    input logic [RW-1:0] have
  );
    logic [RW:0] need;
    need = {1'b0, row} + (RW+1)'(2);
    if (need > (RW+1)'(pIMG_H)) need = (RW+1)'(pIMG_H);
    return {1'b0, have} >= need;
  endfunction

  // Row k>=3 reuses row k-3's slot, so wait until output row k-2 is done.
  always_comb begin
    orow1   = {1'b0, out_row_q} + (RW+1)'(1);
    ready_c = (in_row_q < RW'(pIMG_H)) &&
              ((in_row_q < RW'(KSIZE)) || (orow1 >= {1'b0, in_row_q}));
  end

  assign bus.s_ready = rst_n && ready_c;
  assign wr_en   = bus.s_valid && ready_c;
  assign wr_addr = AW'(in_slot_q) * AW'(pIMG_W) + AW'(in_col_q);

  always_comb begin
    in_col_d  = in_col_q;
    in_row_d  = in_row_q;
    in_slot_d = in_slot_q;
    if (done_q) begin
      in_col_d  = '0;
      in_row_d  = '0;
      in_slot_d = '0;
    end else if (wr_en) begin
      if (in_col_q == CW'(pIMG_W - 1)) begin
        in_col_d  = '0;
        in_row_d  = in_row_q + RW'(1);
        in_slot_d = inc3(in_slot_q);
      end else begin
        in_col_d = in_col_q + CW'(1);
      end
    end
  end

  always_comb begin
    last_col  = out_col_q == CW'(pIMG_W - 1);
    last_row  = out_row_q == RW'(pIMG_H - 1);
    nxt_col   = last_col ? '0 : out_col_q + CW'(1);
    nxt_row   = last_col ? out_row_q + RW'(1) : out_row_q;
    nxt_oslot = last_col ? inc3(out_slot_q) : out_slot_q;
  end

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    out_col_d  = out_col_q;
    out_row_d  = out_row_q;
    out_slot_d = out_slot_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!done_q && bus.win_ready && rows_ok(out_row_q, in_row_q)) begin
          state_d = RUN;
          slot_d  = '0;
        end
      end
      RUN: begin
        if (slot_q == SW'(NSLOTS - 1)) begin
          slot_d = '0;
          if (last_col && last_row) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            out_col_d  = nxt_col;
            out_row_d  = nxt_row;
            out_slot_d = nxt_oslot;
            if (!(bus.win_ready && rows_ok(nxt_row, in_row_q)))
              state_d = IDLE;
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (done_q) begin
      out_col_d  = '0;
      out_row_d  = '0;
      out_slot_d = '0;
    end
  end

  assign issue = state_q == RUN;

  always_comb begin
    ky   = 2'd0;
    base = '0;
    unique case (1'b1)
      (slot_q < SW'(3)): begin
        ky   = 2'd0;
        base = SW'(0);
      end
      (slot_q >= SW'(3) && slot_q < SW'(6)): begin
        ky   = 2'd1;
        base = SW'(3);
      end
      (slot_q >= SW'(6)): begin
        ky   = 2'd2;
        base = SW'(6);
      end
    endcase
    kx = 2'(slot_q - base);
    pad_c = (slot_q == SW'(NSLOTS - 1)) ||
            (ky == 2'd0 && out_row_q == '0) ||
            (ky == 2'd2 && last_row) ||
            (kx == 2'd0 && out_col_q == '0) ||
            (kx == 2'd2 && last_col);
    unique case (ky)
      2'd0:    rd_slot = dec3(out_slot_q);
      2'd1:    rd_slot = out_slot_q;
      default: rd_slot = inc3(out_slot_q);
    endcase
    rd_col  = CW'({1'b0, out_col_q} + (CW+1)'(kx) - (CW+1)'(1));
    rd_addr = pad_c ? '0
            : AW'(rd_slot) * AW'(pIMG_W) + AW'(rd_col);
    rd_en   = issue && !pad_c;
  end

  always_comb begin
    en_d    = issue;
    kaddr_d = kaddr_q;
    if (issue)
      kaddr_d = (slot_q == SW'(NSLOTS - 1)) ? KAW'(NTAPS - 1) : KAW'(slot_q);
    pad_d   = issue ? pad_c : 1'b1;
    first_d = issue && (slot_q == '0);
    last_d  = issue && (slot_q == SW'(NSLOTS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      out_col_q  <= '0;
      out_row_q  <= '0;
      out_slot_q <= '0;
      in_col_q   <= '0;
      in_row_q   <= '0;
      in_slot_q  <= '0;
      en_q       <= 1'b0;
      kaddr_q    <= '0;
      pad_q      <= 1'b1;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      out_col_q  <= out_col_d;
      out_row_q  <= out_row_d;
      out_slot_q <= out_slot_d;
      in_col_q   <= in_col_d;
      in_row_q   <= in_row_d;
      in_slot_q  <= in_slot_d;
      en_q       <= en_d;
      kaddr_q    <= kaddr_d;
      pad_q      <= pad_d;
      first_q    <= first_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  conv1_line_ram #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_ram (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (bus.s_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data_q (rd_data)
  );

  assign bus.en          = en_q;
  assign bus.kernel_addr = kaddr_q;
  assign bus.data_out    = pad_q ? '0 : rd_data;
  assign bus.tap_first   = first_q;
  assign bus.tap_last    = last_q;
  assign bus.frame_done  = done_q;

endmodule

// File: tb/tb_conv1_window_feeder.sv
// Scoreboard bench for conv1_window_feeder on a 4x4 image.
// Expected taps come from a padded-image window model.
module tb_conv1_window_feeder;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 24;

  typedef struct {
    logic [3:0]    addr;
    logic [PW-1:0] data;
    logic          first;
    logic          last;
    logic          done;
  } exp_t;

  logic clk;
  logic rst_n;

  conv1_window_feeder_if #(
    .pDATA_WIDTH (8),
    .pIN_CHANNEL (3),
    .pKERNEL_NUM (9)
  ) bus ();

  conv1_window_feeder #(
    .pDATA_WIDTH (8),
    .pIN_CHANNEL (3),
    .pIMG_W      (W),
    .pIMG_H      (H),
    .pKERNEL_NUM (9)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t          expq[$];
  logic [PW-1:0] pixq[$];
  logic [PW-1:0] img[H][W];
  int total = 0;
  int bad   = 0;
  int gap   = 0;
  int wr_mode = 0;
  int win_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = {3{8'(r * W + c + 1)}};
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = PW'($urandom);
  endtask

  // Windows in raster order; each is 9 zero-padded taps then a zero slot.
  task automatic issue_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        pixq.push_back(img[r][c]);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        for (int t = 0; t < 10; t++) begin
          exp_t e;
          int rr, cc;
          rr = r + t / 3 - 1;
          cc = c + t % 3 - 1;
          e.addr  = (t < 9) ? 4'(t) : 4'd8;
          e.data  = '0;
          if (t < 9 && rr >= 0 && rr < H && cc >= 0 && cc < W)
            e.data = img[rr][cc];
          e.first = (t == 0);
          e.last  = (t == 9);
          e.done  = (t == 9) && (r == H - 1) && (c == W - 1);
          expq.push_back(e);
        end
  endtask

  task automatic wait_frame(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (expq.size() == 0 && pixq.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout(nm);
    repeat (3) @(negedge clk);
  endtask

  initial begin : prod
    logic hs;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    forever begin
      @(negedge clk);
      hs = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (hs && pixq.size() > 0) void'(pixq.pop_front());
      if (pixq.size() > 0 && $urandom_range(0, 99) >= gap) begin
        bus.s_valid = 1'b1;
        bus.s_data  = pixq[0];
      end else begin
        bus.s_valid = 1'b0;
      end
    end
  end

  initial begin : wrdrv
    bus.win_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (wr_mode == 2) bus.win_ready = ($urandom_range(0, 3) != 0);
      else              bus.win_ready = (wr_mode == 1);
    end
  end

  initial begin : mon
    int acc, lasts, irow;
    logic prev_en, prev_last, exp_rdy, clr;
    logic [3:0] last_ka;
    exp_t e;
    acc = 0; lasts = 0; prev_en = 0; prev_last = 0; last_ka = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc = 0; lasts = 0; prev_en = 0; prev_last = 0; last_ka = '0;
        continue;
      end
      clr = 0;
      if (bus.en && bus.tap_last) begin
        lasts++;
        win_seen++;
      end
      irow = acc / W;
      exp_rdy = (irow < H) && (irow < 3 || lasts / W >= irow - 1);
      chk("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
      if (bus.en) begin
        if (expq.size() == 0) begin
          timeout("extra_window_slot");
        end else begin
          e = expq.pop_front();
          chk("tap", {bus.kernel_addr, bus.data_out, bus.tap_first,
                      bus.tap_last, bus.frame_done},
              {e.addr, e.data, e.first, e.last, e.done});
        end
        last_ka = bus.kernel_addr;
        if (bus.frame_done) clr = 1;
      end else begin
        chk("idle_hold", {bus.kernel_addr, bus.frame_done,
                          prev_en && !prev_last},
            {last_ka, 1'b0, 1'b0});
      end
      if (bus.s_valid && bus.s_ready) acc++;
      prev_en   = bus.en;
      prev_last = bus.tap_last;
      if (clr) begin
        acc = 0;
        lasts = 0;
      end
    end
  end

  initial begin : stim
    int base;
    bit hit;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {bus.en, bus.kernel_addr, bus.data_out, bus.tap_first,
                    bus.tap_last, bus.frame_done}, '0);
    chk("rst_ready", 32'(bus.s_ready), 32'd0);
    #2 rst_n = 1'b1;

    wr_mode = 1;
    gap = 0;
    fill_ramp();
    issue_frame();
    wait_frame("frame_basic");

    gap = 30;
    fill_rand();
    issue_frame();
    base = win_seen;
    hit = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (win_seen >= base + 2) begin
        hit = 1;
        break;
      end
    end
    if (!hit) timeout("first_windows");
    wr_mode = 0;
    repeat (15) @(negedge clk);
    chk("win_ready_low_idle", 32'(bus.en), 32'd0);
    wr_mode = 2;
    wait_frame("frame_random");
    wr_mode = 1;
    repeat (2) @(negedge clk);

    gap = 0;
    fill_ramp();
    issue_frame();
    hit = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (bus.en && bus.kernel_addr == 4'd4) begin
        hit = 1;
        break;
      end
    end
    if (!hit) timeout("slot4");
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", {bus.en, bus.kernel_addr, bus.data_out,
                          bus.tap_first, bus.tap_last, bus.frame_done}, '0);
    chk("async_rst_ready", 32'(bus.s_ready), 32'd0);
    expq.delete();
    pixq.delete();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill_ramp();
    issue_frame();
    wait_frame("frame_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv1_window_feeder.md
Name: conv1_window_feeder

Overview:
Upstream feeder for the conv1 MAC datapath (3x3 kernel, stride 1, zero padding 1). It accepts a raster stream of packed pIN_CHANNEL-channel pixels and buffers three image rows in a ring of line memories. For every output position it emits the 9 kernel taps serially, with a matching kernel_addr, followed by one zero slot. This 10-slot cadence matches the datapath's 10-cycle zero-point-correction counter.

Parameters:
pDATA_WIDTH, 8, bits per channel sample
pIN_CHANNEL, 3, channels packed per pixel
pIMG_W, 32, image width in pixels (≥3)
pIMG_H, 32, image height in pixels (≥3)
pKERNEL_NUM, 9, taps per window; fixed at 9 (3x3)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid&&s_ready
s_data  in  pDATA_WIDTH*pIN_CHANNEL  packed pixel, channel 0 in LSBs
win_ready  in  1  datapath can take a new window; sampled only at window boundaries
en  out  1  tap slot valid; drives datapath en
kernel_addr  out  $clog2(pKERNEL_NUM)  tap index 0..8
data_out  out  pDATA_WIDTH*pIN_CHANNEL  tap pixel (zero when padded or in the dummy slot)
tap_first  out  1  high with slot 0 of a window
tap_last  out  1  high with slot 9 (dummy) of a window
frame_done  out  1  one-cycle pulse with tap_last of the frame's final window

Behaviour:
- Reset: asynchronous on rst_n low. Every output is 0, counters are cleared and the FSM goes to IDLE. A reset mid-frame discards all buffered rows; no partial window completes.
- Line memory: 3*pIMG_W words of pDATA_WIDTH*pIN_CHANNEL bits.
  - Input row k is written to slot k%3, address slot*pIMG_W+col.
  - Synchronous read, 1-cycle latency.
- Input side:
  - Counters in_col and in_row; rows_in = number of complete rows received.
  - s_ready = (in_row < pIMG_H) && (in_row < 3 || out_row ≥ in_row-1). Row k≥3 may overwrite a slot only after output rows 0..k-2 are complete.
  - At the end of the frame, s_ready stays 0 until frame_done. After frame_done all counters return to 0 and s_ready reasserts the next cycle.
- Output FSM:
  - IDLE: go to RUN when win_ready=1 and rows_in ≥ min(out_row+2, pIMG_H).
  - RUN: slot counter runs 0..9, one slot per cycle, never stalls mid-window.
  - At slot 9: advance out_col; wrap to 0 and increment out_row at pIMG_W-1. Re-evaluate the IDLE condition and stay in RUN back-to-back if it holds, otherwise go to IDLE.
  - After the last window (out_row=pIMG_H-1, out_col=pIMG_W-1), go to IDLE and clear the frame.
- Tap mapping:
  - Slot t<9: ky=t/3, kx=t%3, input coordinate (out_row+ky-1, out_col+kx-1).
  - Out-of-range row or column: data_out=0 (padding mask registered alongside the read).
  - Slot 9: data_out=0, kernel_addr=8.
- Alignment: address, mask and slot info are issued in cycle n. In cycle n+1, en, kernel_addr, data_out, tap_first and tap_last appear together, all registered.
  - en=1 for exactly 10 consecutive cycles per window; en=0 otherwise.
  - kernel_addr holds its last value while en=0.
- Simultaneous events: an input write and an output read in the same cycle always target different slots under the s_ready rule, so no bypass is required.
- Width rule: counters are $clog2 of their bound; no arithmetic on pixel data.

Decomposition:
- Shared package conv1_pkg:
  - localparams for kernel size 3, tap count 9, slots per window 10.
  - Output FSM state enum {IDLE, RUN}.
- One sub-module: conv1_line_ram, a simple dual-port synchronous RAM (write port and read port), parameterised by depth and width, inferred as block RAM.

Test Plan:
- Basic window (pIMG_W=pIMG_H=4, pixel value = row*4+col+1 replicated on all channels):
  - Window (0,0) data_out per channel = 0,0,0,0,1,2,0,5,6 then 0.
  - kernel_addr = 0..8,8; tap_first on slot 0, tap_last on slot 9.
- Interior window: window (1,1) emits 1,2,3,5,6,7,9,10,11,0.
- Corner window: window (3,3) emits 11,12,0,15,16,0,0,0,0,0. frame_done pulses with its tap_last, after exactly 16 windows = 160 en cycles.
- Backpressure: s_valid held high.
  - s_ready drops after row 2 and reasserts only after output row 1 completes.
  - All 16 pixels are accepted exactly once.
- win_ready low at a boundary:
  - The FSM idles with en=0.
  - Raising win_ready resumes at the next out_col with no lost or duplicated window.
- Reset mid-window: pulse rst_n low at slot 4.
  - Outputs go to 0 immediately (asynchronous).
  - A fresh frame afterwards reproduces the Basic-window sequence.
